// File: rtl/sar_pkg.sv
// Shared types, defaults and the code-to-voltage transfer function for the SAR controller.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } sar_state_t;

    localparam int unsigned SAR_N_BITS_DEFAULT = 8;
    localparam int unsigned SAR_CODE_W_MAX     = 16;

    // Ideal binary-weighted DAC: vref_l + (vref_h - vref_l) * code / 2^n.
    function automatic real code_to_volt(
        input logic [SAR_CODE_W_MAX-1:0] code,
        input real                       vref_l,
        input real                       vref_h,
        input int unsigned               n
    );
        return vref_l + (vref_h - vref_l) * real'(code) / real'(64'(1) << n);
    endfunction

endpackage

// File: rtl/sar_code_dac.sv
// Combinational capacitor-matrix DAC model: maps a code onto the reference span.
module sar_code_dac
    import sar_pkg::*;
#(
    parameter int unsigned N_BITS = SAR_N_BITS_DEFAULT
) (
    input  logic [N_BITS-1:0] i_code,
    input  real               i_vref_l,
    input  real               i_vref_h,
    output real               o_volt
);

    always_comb begin
        o_volt = code_to_volt(16'(i_code), i_vref_l, i_vref_h, N_BITS);
    end

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: IDLE -> SAMPLE -> CONVERT (N_BITS cycles) -> DONE.
// Define SAR_CTRL_ASSERT_EN to elaborate the protocol and result checkers.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned N_BITS = SAR_N_BITS_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  real               i_Vin,
    input  real               i_Vref_H,
    input  real               i_Vref_L,
    output logic              o_Sprg,
    output logic              o_Ssmpl,
    output real               o_Vdac_mat,
    output logic [N_BITS-1:0] o_code,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned K_W = $clog2(N_BITS);

    sar_state_t        state_q, state_d;
    logic [N_BITS-1:0] code_q, code_d;
    logic [K_W-1:0]    bit_q, bit_d;
    real               vs_q, vs_d;
    logic              sprg_q, sprg_d;
    logic              ssmpl_q, ssmpl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [N_BITS-1:0] trial_c;
    logic [N_BITS-1:0] dac_code_c;

    // The DAC shows the trial code while converting, the settled code otherwise.
    always_comb begin
        trial_c    = code_q | (N_BITS'(1) << bit_q);
        dac_code_c = (state_q == ST_CONVERT) ? trial_c : code_q;
    end

    sar_code_dac #(
        .N_BITS(N_BITS)
    ) u_dac (
        .i_code  (dac_code_c),
        .i_vref_l(i_Vref_L),
        .i_vref_h(i_Vref_H),
        .o_volt  (o_Vdac_mat)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        bit_d   = bit_q;
        vs_d    = vs_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                vs_d    = i_Vin;
                code_d  = '0;
                bit_d   = K_W'(N_BITS - 1);
                state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (vs_q >= o_Vdac_mat) code_d = trial_c;
                if (bit_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    bit_d = bit_q - K_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they line up with state_q.
        sprg_d  = (state_d == ST_DONE);
        ssmpl_d = (state_d == ST_SAMPLE);
        busy_d  = (state_d == ST_SAMPLE) || (state_d == ST_CONVERT);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            bit_q   <= '0;
            vs_q    <= 0.0;
            sprg_q  <= 1'b0;
            ssmpl_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            bit_q   <= bit_d;
            vs_q    <= vs_d;
            sprg_q  <= sprg_d;
            ssmpl_q <= ssmpl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_Sprg  = sprg_q;
    assign o_Ssmpl = ssmpl_q;
    assign o_code  = code_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

`ifdef SAR_CTRL_ASSERT_EN
    int unsigned conv_cnt_q;
    logic        lo_ok_c;
    logic        hi_ok_c;

    always_ff @(posedge i_clk) begin
        if (i_rst || (state_q != ST_CONVERT)) begin
            conv_cnt_q <= '0;
        end else begin
            conv_cnt_q <= conv_cnt_q + 32'd1;
        end
    end

    // Final code must bracket the held sample; inputs below Vref_L legitimately give 0.
    always_comb begin
        lo_ok_c = (code_q == '0) ||
                  (vs_q >= code_to_volt(16'(code_q), i_Vref_L, i_Vref_H, N_BITS));
        hi_ok_c = (code_q == '1) ||
                  (vs_q < code_to_volt(16'(code_q) + 16'd1, i_Vref_L, i_Vref_H, N_BITS));
    end

    a_ctrl_not_both: assert property (@(posedge i_clk) !(o_Sprg && o_Ssmpl));
    a_done_pulse: assert property (@(posedge i_clk) disable iff (i_rst) o_done |=> !o_done);
    a_busy_not_done: assert property (@(posedge i_clk) o_busy |-> !o_done);
    a_conv_len: assert property (@(posedge i_clk) disable iff (i_rst)
        (state_q == ST_DONE) |-> (conv_cnt_q == N_BITS));
    a_result_range: assert property (@(posedge i_clk) disable iff (i_rst)
        (state_q == ST_DONE) |-> (lo_ok_c && hi_ok_c));
`else
    // No checkers elaborated; datapath and FSM are identical either way.
`endif

endmodule

// File: tb/tb_sar_ctrl.sv
// Bench for sar_ctrl (N_BITS=8): vector table plus reset-abort and back-to-back sequences.
module tb_sar_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    real        i_Vin;
    real        i_Vref_H;
    real        i_Vref_L;
    logic       o_Sprg;
    logic       o_Ssmpl;
    real        o_Vdac_mat;
    logic [7:0] o_code;
    logic       o_busy;
    logic       o_done;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        real        vref_l;
        real        vref_h;
        real        vin;
        real        vin_late;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[14];

    always #5 i_clk = ~i_clk;

    sar_ctrl #(
        .N_BITS(8)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_Vin     (i_Vin),
        .i_Vref_H  (i_Vref_H),
        .i_Vref_L  (i_Vref_L),
        .o_Sprg    (o_Sprg),
        .o_Ssmpl   (o_Ssmpl),
        .o_Vdac_mat(o_Vdac_mat),
        .o_code    (o_code),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_r(input string name, input real act, input real exp);
        checks++;
        if ((act - exp > 1.0e-9) || (exp - act > 1.0e-9)) begin
            failures++;
            $display("FAIL %s actual=%f required=%f @%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and control-encoding monitor, sampled mid-cycle.
    always @(negedge i_clk) begin
        logic [7:0] e;
        checks++;
        if (o_Sprg && o_Ssmpl) begin
            failures++;
            $display("FAIL ctrl_both_high actual=11 required=not11 @%0t", $time);
        end
        if (o_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 @%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (o_code !== e) begin
                    failures++;
                    $display("FAIL result_code actual=%0h required=%0h @%0t", o_code, e, $time);
                end
            end
        end
    end

    task automatic run_conv(input real vin, input real vin_late, input logic [7:0] exp);
        int  lat;
        real span;
        span = i_Vref_H - i_Vref_L;
        i_Vin = vin;
        exp_q.push_back(exp);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("sample_ssmpl", 32'(o_Ssmpl), 32'd1);
        chk("sample_sprg", 32'(o_Sprg), 32'd0);
        chk("sample_busy", 32'(o_busy), 32'd1);
        tick();
        i_Vin = vin_late;
        chk("conv_ssmpl", 32'(o_Ssmpl), 32'd0);
        chk("conv_busy", 32'(o_busy), 32'd1);
        chk_r("conv_first_trial", o_Vdac_mat, i_Vref_L + span * 0.5);
        lat = 1;
        while (!o_done && lat < 30) begin
            tick();
            lat++;
        end
        chk("done_latency", 32'(lat), 32'd9);
        chk("done_sprg", 32'(o_Sprg), 32'd1);
        chk("done_busy", 32'(o_busy), 32'd0);
        chk_r("done_vdac", o_Vdac_mat, i_Vref_L + span * real'(exp) / 256.0);
        tick();
        chk("done_one_cycle", 32'(o_done), 32'd0);
        chk("code_hold", 32'(o_code), 32'(exp));
    endtask

    initial begin
        int done_cnt;
        int smpl_cnt;

        vecs[0]  = '{0.0, 1.0, 0.5, 0.5, 8'h80};
        vecs[1]  = '{0.0, 1.0, 0.3, 0.3, 8'h4C};
        vecs[2]  = '{0.0, 1.0, 0.0, 0.0, 8'h00};
        vecs[3]  = '{0.0, 1.0, 1.0, 1.0, 8'hFF};
        vecs[4]  = '{0.0, 1.0, 1.5, 1.5, 8'hFF};
        vecs[5]  = '{0.0, 1.0, 0.25, 0.9, 8'h40};
        vecs[6]  = '{0.0, 1.0, 0.75, 0.75, 8'hC0};
        vecs[7]  = '{0.0, 1.0, -0.2, -0.2, 8'h00};
        vecs[8]  = '{0.0, 1.0, 0.126953125, 0.126953125, 8'h20};
        vecs[9]  = '{0.0, 1.0, 0.00390625, 0.00390625, 8'h01};
        vecs[10] = '{0.25, 1.25, 0.75, 0.75, 8'h80};
        vecs[11] = '{0.25, 1.25, 0.125, 0.125, 8'h00};
        vecs[12] = '{0.25, 1.25, 1.25, 1.25, 8'hFF};
        vecs[13] = '{0.25, 1.25, 0.58203125, 0.58203125, 8'h55};

        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_Vin    = 0.0;
        i_Vref_L = 0.0;
        i_Vref_H = 1.0;
        tick();
        tick();
        chk("rst_code", 32'(o_code), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_sprg", 32'(o_Sprg), 32'd0);
        chk("rst_ssmpl", 32'(o_Ssmpl), 32'd0);
        chk_r("rst_vdac", o_Vdac_mat, 0.0);
        i_rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            i_Vref_L = vecs[i].vref_l;
            i_Vref_H = vecs[i].vref_h;
            run_conv(vecs[i].vin, vecs[i].vin_late, vecs[i].exp_code);
        end

        // Reset during the fourth CONVERT cycle aborts without a done pulse.
        i_Vref_L = 0.0;
        i_Vref_H = 1.0;
        i_Vin    = 0.5;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        i_rst = 1'b1;
        tick();
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_code", 32'(o_code), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_sprg", 32'(o_Sprg), 32'd0);
        chk("abort_ssmpl", 32'(o_Ssmpl), 32'd0);
        chk_r("abort_vdac", o_Vdac_mat, 0.0);
        i_rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (o_done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Start held for 20 cycles: exactly two back-to-back conversions.
        i_Vin = 0.25;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h40);
        done_cnt = 0;
        smpl_cnt = 0;
        i_start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 19) i_start = 1'b0;
            if (o_done) done_cnt++;
            if (o_Ssmpl) smpl_cnt++;
        end
        chk("b2b_done_count", 32'(done_cnt), 32'd2);
        chk("b2b_sample_count", 32'(smpl_cnt), 32'd2);
        chk("b2b_code", 32'(o_code), 32'h40);

        // Cleared code with offset references sits at Vref_L.
        i_Vref_L = 0.25;
        i_Vref_H = 1.25;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
        chk_r("zero_code_vdac", o_Vdac_mat, 0.25);

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
